// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one big-endian instruction memory port between
// the CPU fetch path and the program loader. Each access is sequenced by a
// small FSM. Addresses are range/alignment checked. Loader writes are
// verified by reading the word back.
module imem_port_arbiter #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             FetchReq,
  input  logic [31:0]      FetchAddr,
  output logic [31:0]      FetchData,
  output logic             FetchValid,
  output logic             FetchErr,
  input  logic             LoadReq,
  input  logic [31:0]      LoadAddr,
  input  logic [31:0]      LoadData,
  output logic             LoadAck,
  output logic             LoadErr,
  output logic [CNT_W-1:0] WriteCount,
  output logic             Busy,
  output logic [31:0]      IAddr,
  output logic [31:0]      IDataIn,
  output logic             RW,
  input  logic [31:0]      IDataOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_VERIFY,
    S_DONE
  } state_t;

  localparam logic [31:0]      MAX_ADDR    = 32'(DEPTH - 4);
  localparam logic             GRANT_FETCH = 1'b0;
  localparam logic             GRANT_LOAD  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [31:0]        fetch_data_q, fetch_data_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               fetch_err_q, fetch_err_d;
  logic               load_ack_q, load_ack_d;
  logic               load_err_q, load_err_d;
  logic [CNT_W-1:0]   write_count_q, write_count_d;
  logic [31:0]        iaddr_q, iaddr_d;
  logic [31:0]        idatain_q, idatain_d;
  logic               rw_q, rw_d;

  logic               grant_load;
  logic [31:0]        sel_addr;
  logic               addr_legal;

  // Next-state and output logic; done/err pulses default low so they last one cycle
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    fetch_data_d  = fetch_data_q;
    fetch_valid_d = 1'b0;
    fetch_err_d   = 1'b0;
    load_ack_d    = 1'b0;
    load_err_d    = 1'b0;
    write_count_d = write_count_q;
    iaddr_d       = iaddr_q;
    idatain_d     = idatain_q;
    rw_d          = rw_q;
    grant_load    = 1'b0;
    sel_addr      = FetchAddr;
    addr_legal    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (FetchReq || LoadReq) begin
          // On a tie, the side that did not win last time goes first
          grant_load   = LoadReq && (!FetchReq || (last_grant_q == GRANT_FETCH));
          last_grant_d = grant_load ? GRANT_LOAD : GRANT_FETCH;
          sel_addr     = grant_load ? LoadAddr : FetchAddr;
          addr_legal   = (sel_addr[1:0] == 2'b00) && (sel_addr <= MAX_ADDR);
          if (!addr_legal) begin
            // Rejected address: report straight away, memory port untouched
            state_d = S_DONE;
            if (grant_load) begin
              load_ack_d = 1'b1;
              load_err_d = 1'b1;
            end else begin
              fetch_valid_d = 1'b1;
              fetch_err_d   = 1'b1;
            end
          end else if (grant_load) begin
            state_d   = S_WRITE;
            iaddr_d   = sel_addr;
            idatain_d = LoadData;
            rw_d      = 1'b0;
          end else begin
            state_d = S_FETCH;
            iaddr_d = sel_addr;
            rw_d    = 1'b1;
          end
        end
      end
      S_FETCH: begin
        fetch_data_d  = IDataOut;
        fetch_valid_d = 1'b1;
        state_d       = S_DONE;
      end
      S_WRITE: begin
        // Same address is kept; switch to read for the verify cycle
        rw_d    = 1'b1;
        state_d = S_VERIFY;
      end
      S_VERIFY: begin
        load_ack_d = 1'b1;
        if (IDataOut != idatain_q) begin
          load_err_d = 1'b1;
        end else if (write_count_q != CNT_MAX) begin
          write_count_d = write_count_q + CNT_ONE;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= GRANT_LOAD;
      fetch_data_q  <= 32'h0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      load_ack_q    <= 1'b0;
      load_err_q    <= 1'b0;
      write_count_q <= {CNT_W{1'b0}};
      iaddr_q       <= 32'h0;
      idatain_q     <= 32'h0;
      rw_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      load_ack_q    <= load_ack_d;
      load_err_q    <= load_err_d;
      write_count_q <= write_count_d;
      iaddr_q       <= iaddr_d;
      idatain_q     <= idatain_d;
      rw_q          <= rw_d;
    end
  end

  assign FetchData  = fetch_data_q;
  assign FetchValid = fetch_valid_q;
  assign FetchErr   = fetch_err_q;
  assign LoadAck    = load_ack_q;
  assign LoadErr    = load_err_q;
  assign WriteCount = write_count_q;
  assign Busy       = (state_q != S_IDLE);
  assign IAddr      = iaddr_q;
  assign IDataIn    = idatain_q;
  assign RW         = rw_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: byte-array memory model, directed vector
// table, randomized transactions against a word-level reference model, and
// hand-written sequences for arbitration, stuck memory and mid-flight reset.
module tb_imem_port_arbiter;

  localparam int DEPTH = 256;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             Reset = 1'b0;
  logic             FetchReq = 1'b0;
  logic [31:0]      FetchAddr = 32'h0;
  logic [31:0]      FetchData;
  logic             FetchValid;
  logic             FetchErr;
  logic             LoadReq = 1'b0;
  logic [31:0]      LoadAddr = 32'h0;
  logic [31:0]      LoadData = 32'h0;
  logic             LoadAck;
  logic             LoadErr;
  logic [CNT_W-1:0] WriteCount;
  logic             Busy;
  logic [31:0]      IAddr;
  logic [31:0]      IDataIn;
  logic             RW;
  logic [31:0]      IDataOut;

  always #5 clk = ~clk;

  imem_port_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(clk), .Reset(Reset),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchData(FetchData),
    .FetchValid(FetchValid), .FetchErr(FetchErr),
    .LoadReq(LoadReq), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .LoadAck(LoadAck), .LoadErr(LoadErr), .WriteCount(WriteCount),
    .Busy(Busy), .IAddr(IAddr), .IDataIn(IDataIn), .RW(RW), .IDataOut(IDataOut)
  );

  // Memory model: big-endian bytes, combinational read, write on clock edge
  logic [7:0]  mem [0:255];
  logic        stuck = 1'b0;
  logic        bd_en = 1'b0;
  logic [7:0]  bd_addr = 8'h0;
  logic [31:0] bd_word = 32'h0;

  always @(posedge clk) begin
    if (bd_en) begin
      mem[bd_addr]        <= bd_word[31:24];
      mem[bd_addr + 8'd1] <= bd_word[23:16];
      mem[bd_addr + 8'd2] <= bd_word[15:8];
      mem[bd_addr + 8'd3] <= bd_word[7:0];
    end else if (RW === 1'b0 && !stuck) begin
      mem[IAddr[7:0]]        <= IDataIn[31:24];
      mem[IAddr[7:0] + 8'd1] <= IDataIn[23:16];
      mem[IAddr[7:0] + 8'd2] <= IDataIn[15:8];
      mem[IAddr[7:0] + 8'd3] <= IDataIn[7:0];
    end
  end

  assign IDataOut = {mem[IAddr[7:0]], mem[IAddr[7:0] + 8'd1],
                     mem[IAddr[7:0] + 8'd2], mem[IAddr[7:0] + 8'd3]};

  int rw0_total = 0;
  always @(negedge clk) begin
    if (RW === 1'b0) rw0_total <= rw0_total + 1;
  end

  // Reference model state (word granular)
  logic [31:0] ref_word [0:63];
  logic [31:0] last_fetch = 32'h0;
  int          model_cnt = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;
  vec_t tbl [11];

  function automatic bit addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'(DEPTH - 4));
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    ref_word[a[7:2]] = w;
    bd_addr = a[7:0];
    bd_word = w;
    bd_en = 1'b1;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    logic [127:0] act, exp;
    act = {FetchData, FetchValid, FetchErr, LoadAck, LoadErr, WriteCount, Busy, IAddr, IDataIn, RW};
    exp = {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, {CNT_W{1'b0}}, 1'b0, 32'h0, 32'h0, 1'b1};
    chk(name, act, exp);
  endtask

  task automatic do_reset(input string name);
    FetchReq = 1'b0;
    LoadReq  = 1'b0;
    Reset    = 1'b0;
    @(posedge clk); #1;
    check_reset_vals(name);
    Reset      = 1'b1;
    model_cnt  = 0;
    last_fetch = 32'h0;
  endtask

  // One request from a single requester, checked for latency, error, data,
  // busy, write strobe and write count; then the model is advanced.
  task automatic do_txn(input bit is_load, input logic [31:0] addr, input logic [31:0] data,
                        input bit exp_err, input logic [31:0] exp_data, input int exp_lat,
                        input string name);
    int n, busy_n, rw_start, exp_rw0;
    bit done;
    @(posedge clk); #1;
    rw_start = rw0_total;
    if (is_load) begin
      LoadAddr = addr; LoadData = data; LoadReq = 1'b1;
    end else begin
      FetchAddr = addr; FetchReq = 1'b1;
    end
    n = 0; busy_n = 0; done = 1'b0;
    while (!done && n < 8) begin
      @(posedge clk); #1;
      n++;
      if (Busy) busy_n++;
      done = is_load ? LoadAck : FetchValid;
    end
    FetchReq = 1'b0;
    LoadReq  = 1'b0;
    exp_rw0 = (is_load && exp_lat == 3) ? 1 : 0;
    if (is_load && !exp_err && model_cnt < (1 << CNT_W) - 1) model_cnt++;
    if (is_load && exp_lat == 3 && !stuck) ref_word[addr[7:2]] = data;
    $display("txn %s: %s addr=%08h data=%08h lat=%0d err=%0b", name,
             is_load ? "load " : "fetch", addr, is_load ? data : FetchData, n,
             is_load ? LoadErr : FetchErr);
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_busy"}, busy_n, exp_lat);
    chk({name, "_err"}, is_load ? LoadErr : FetchErr, exp_err);
    chk({name, "_rw0"}, rw0_total - rw_start, exp_rw0);
    chk({name, "_cnt"}, WriteCount, model_cnt);
    if (!is_load) begin
      chk({name, "_data"}, FetchData, exp_data);
      if (!exp_err) last_fetch = exp_data;
    end
  endtask

  initial begin
    int nev, cyc, noack;
    bit is_load;
    logic [31:0] a, d, ed;
    bit err;

    tbl[0]  = '{1'b0, 32'h0000_0008, 32'h0,          1'b0, 32'h1234_5678, 2};
    tbl[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  1'b0, 32'h0,         3};
    tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'hDEAD_BEEF, 2};
    tbl[3]  = '{1'b0, 32'h0000_0006, 32'h0,          1'b1, 32'hDEAD_BEEF, 1};
    tbl[4]  = '{1'b1, 32'h0000_0100, 32'h1111_2222,  1'b1, 32'h0,         1};
    tbl[5]  = '{1'b0, 32'h0000_00FC, 32'h0,          1'b0, 32'hA5A5_5A5A, 2};
    tbl[6]  = '{1'b1, 32'h0000_00FC, 32'h0BAD_F00D,  1'b0, 32'h0,         3};
    tbl[7]  = '{1'b0, 32'h0000_00FC, 32'h0,          1'b0, 32'h0BAD_F00D, 2};
    tbl[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,          1'b1, 32'h0BAD_F00D, 1};
    tbl[9]  = '{1'b1, 32'h0000_00FD, 32'h3333_4444,  1'b1, 32'h0,         1};
    tbl[10] = '{1'b0, 32'h0000_0002, 32'h0,          1'b1, 32'h0BAD_F00D, 1};

    // Reset state
    @(posedge clk); #1;
    do_reset("reset_init");

    // Fill memory with random words, then the directed test words
    for (int w = 0; w < 64; w++) set_word(32'(w * 4), $urandom);
    set_word(32'h8, 32'h1234_5678);
    set_word(32'hFC, 32'hA5A5_5A5A);

    for (int i = 0; i < 11; i++)
      do_txn(tbl[i].is_load, tbl[i].addr, tbl[i].data, tbl[i].exp_err,
             tbl[i].exp_data, tbl[i].exp_lat, $sformatf("tbl%0d", i));

    // Stuck memory: write does not land, read-back mismatch must be flagged
    set_word(32'h20, 32'h0);
    stuck = 1'b1;
    do_txn(1'b1, 32'h20, 32'h1, 1'b1, 32'h0, 3, "stuck");
    stuck = 1'b0;

    // Randomized transactions against the reference model
    for (int i = 0; i < 60; i++) begin
      is_load = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1:    a = {24'h0, 6'($urandom), 2'b00};
        2:       a = {24'h0, 8'($urandom)};
        default: a = $urandom;
      endcase
      d   = $urandom;
      err = !addr_ok(a);
      ed  = err ? last_fetch : ref_word[a[7:2]];
      do_txn(is_load, a, d, err, ed, err ? 1 : (is_load ? 3 : 2), $sformatf("rnd%0d", i));
    end

    // Reset while the load is in VERIFY: no ack, write not counted
    @(posedge clk); #1;
    LoadAddr = 32'h30; LoadData = 32'hCAFE_F00D; LoadReq = 1'b1;
    @(posedge clk); #1;
    chk("rstv_write_rw", RW, 1'b0);
    @(posedge clk); #1;
    chk("rstv_verify_addr", {RW, IAddr}, {1'b1, 32'h30});
    do_reset("rstv_reset");
    ref_word[12] = 32'hCAFE_F00D;
    noack = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (LoadAck) noack++;
    end
    chk("rstv_no_ack", noack, 0);
    do_txn(1'b0, 32'h30, 32'h0, 1'b0, 32'hCAFE_F00D, 2, "rstv_fetch");

    // Both requesters held: grants must alternate fetch, load, ...
    do_reset("rr_reset");
    FetchAddr = 32'h0; LoadAddr = 32'h40; LoadData = 32'h55AA_00FF;
    FetchReq = 1'b1; LoadReq = 1'b1;
    nev = 0; cyc = 0;
    while (nev < 10 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (FetchValid) begin
        $display("txn rr%0d: fetch granted", nev);
        chk($sformatf("rr%0d_kind", nev), nev % 2, 0);
        chk($sformatf("rr%0d_fdata", nev), FetchData, ref_word[0]);
        nev++;
      end
      if (LoadAck) begin
        $display("txn rr%0d: load granted", nev);
        chk($sformatf("rr%0d_kind", nev), nev % 2, 1);
        chk($sformatf("rr%0d_lerr", nev), LoadErr, 1'b0);
        nev++;
      end
    end
    FetchReq = 1'b0; LoadReq = 1'b0;
    chk("rr_events", nev, 10);
    ref_word[16] = 32'h55AA_00FF;
    model_cnt = 5;
    chk("rr_cnt", WriteCount, model_cnt);
    do_txn(1'b0, 32'h40, 32'h0, 1'b0, ref_word[16], 2, "rr_readback");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Controller that shares the byte-addressed, big-endian instruction memory (DEPTH bytes, combinational read, write when RW=0) between the CPU fetch path and the program loader. It sequences every access, checks addresses, verifies each loader write by read-back, and returns results over req/done handshakes. It sits between the PC/fetch logic, the loader, and the instruction memory port.

## Interface
- DEPTH, 256, memory size in bytes; legal word addresses 0..DEPTH-4, multiple of 4
- CNT_W, 16, width of WriteCount
- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- FetchReq  in  1  fetch request, held until FetchValid
- FetchAddr  in  32  fetch byte address, stable while FetchReq=1
- FetchData  out  32  fetched word
- FetchValid  out  1  one-cycle done pulse for fetch
- FetchErr  out  1  qualifies FetchValid: address rejected
- LoadReq  in  1  loader write request, held until LoadAck
- LoadAddr  in  32  write byte address
- LoadData  in  32  word to write
- LoadAck  out  1  one-cycle done pulse for load
- LoadErr  out  1  qualifies LoadAck: address rejected or read-back mismatch
- WriteCount  out  CNT_W  count of verified writes, saturating
- Busy  out  1  high in any state other than IDLE
- IAddr  out  32  memory address
- IDataIn  out  32  memory write data
- RW  out  1  1=read, 0=write
- IDataOut  in  32  memory read data

## Operation
- States: IDLE, FETCH, WRITE, VERIFY, DONE.
- IDLE: samples requests. Winner's address/data latched. Address legal iff addr[1:0]=0 and addr <= DEPTH-4 (unsigned).
- Arbitration: only one requester -> it wins. Both -> round-robin via LastGrant (reset = LOAD, so first tie goes to fetch); LastGrant updates on every grant, legal or not.
- Illegal address: IDLE -> DONE with Err=1, no memory access (RW stays 1).
- Legal fetch: IDLE -> FETCH (IAddr=addr, RW=1); capture IDataOut into FetchData at end of FETCH -> DONE.
- Legal load: IDLE -> WRITE (IAddr=addr, IDataIn=data, RW=0) -> VERIFY (same IAddr, RW=1); compare IDataOut with latched data at end of VERIFY -> DONE. Mismatch sets LoadErr; match increments WriteCount (holds at 2^CNT_W-1).
- DONE: pulse FetchValid or LoadAck (with Err) for exactly one cycle; no grant in DONE -> IDLE.
- FetchData holds last value until next fetch completes; unchanged on FetchErr.
- Requests deasserted before done: transaction still completes; done pulse still issued.

## Timing
- Reset values: FetchData=0, FetchValid=0, FetchErr=0, LoadAck=0, LoadErr=0, WriteCount=0, Busy=0, IAddr=0, IDataIn=0, RW=1, state IDLE, LastGrant=LOAD.
- IAddr, IDataIn, RW change only at clock edges; RW=0 for exactly the WRITE cycle, IAddr unchanged WRITE->VERIFY.
- Latency from request sampled in IDLE at edge k: legal fetch FetchValid high cycle k+2; legal load LoadAck high cycle k+3; illegal either, done high cycle k+1.
- Requester must drop Req at the edge where it sees done; IDLE after DONE therefore sees no stale request. Back-to-back: new request granted in IDLE, so peak fetch rate one word per 3 cycles.
- Reset low mid-operation: next edge returns all to reset values; in-flight transaction dropped, no done pulse; a write already issued may be in memory but is not counted.

## Test plan
- Fetch 0x00000008 with memory bytes 8..11 = 12,34,56,78 -> FetchValid at k+2, FetchData=0x12345678, FetchErr=0, Busy high cycles k+1..k+2.
- Load 0x00000010 data 0xDEADBEEF -> RW=0 only cycle k+1, LoadAck at k+3, LoadErr=0, WriteCount=1; subsequent fetch of 0x10 returns 0xDEADBEEF.
- Fetch 0x00000006 and load 0x00000100 (DEPTH=256) -> each done at k+1 with Err=1, RW never 0, WriteCount unchanged.
- FetchReq and LoadReq both held continuously after reset -> grants alternate fetch, load, fetch, load; no starvation over 10 transactions.
- Memory model forcing write of 0x00000000 to fail (stuck) on load 0x20 data 0x1 -> LoadAck with LoadErr=1, WriteCount unchanged.
- Reset low during VERIFY -> next cycle all outputs at reset values, no LoadAck; new fetch after release completes normally at k+2.
